// File: rtl/inst_fetch_resp.sv
// rtl/inst_fetch_resp.sv - instruction fetch request/response sequencer for an SRAM-like bus
//
// Issues one fetch at a time on an SRAM-like instruction bus and returns the
// fetched word to the decode stage. It handles flush, decode stall (through a
// one-entry hold buffer) and misaligned fetch addresses.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   pc, ce              fetch address and fetch enable from the PC generator
//   flush, stall        pipeline flush and IF/ID stall
//   pc_read_ready       one-cycle pulse when the fetch address is accepted by the bus
//   mem_req, mem_addr   bus request and address (pc with bits [31:29] cleared)
//   mem_addr_ok         bus accepted the address
//   mem_data_ok         bus returns read data on mem_rdata
//   inst_o, inst_pc_o   fetched instruction and its pc
//   inst_valid_o        one-cycle valid for inst_o/inst_pc_o
//   adel_o              fetch address error (misaligned pc)
module inst_fetch_resp #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic        flush,
  input  logic        stall,
  output logic        pc_read_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        adel_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        discard;
  logic        hold_valid;
  logic [31:0] req_pc;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  logic can_fetch;
  logic issue;
  logic misaligned;
  logic data_accept;

  // A fetch may start only from IDLE with nothing parked in the hold buffer.
  assign can_fetch   = (state == IDLE) && ce && !flush && !hold_valid;
  assign issue       = can_fetch && (pc[1:0] == 2'b00);
  assign misaligned  = can_fetch && (pc[1:0] != 2'b00);
  assign data_accept = (state == DATA) && mem_data_ok && !discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_addr      = 32'h0000_0000;
    pc_read_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (issue) begin
            mem_req       = 1'b1;
            mem_addr      = {3'b000, pc[28:0]};
            pc_read_ready = mem_addr_ok;
            state_next    = mem_addr_ok ? DATA : REQ;
          end
        end
        REQ: begin
          // Once raised, the request stays up with a frozen address until accepted.
          mem_req  = 1'b1;
          mem_addr = {3'b000, req_pc[28:0]};
          if (mem_addr_ok) begin
            pc_read_ready = !discard && !flush;
            state_next    = DATA;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      discard      <= 1'b0;
      hold_valid   <= 1'b0;
      req_pc       <= 32'h0000_0000;
      hold_inst    <= NOP_INST;
      hold_pc      <= 32'h0000_0000;
      inst_o       <= NOP_INST;
      inst_pc_o    <= 32'h0000_0000;
      inst_valid_o <= 1'b0;
      adel_o       <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      inst_o       <= NOP_INST;
      adel_o       <= 1'b0;

      if (issue) begin
        req_pc <= pc;
      end

      // The transaction in flight always completes; discard only marks its
      // data as stale and is consumed by the data return.
      if ((state == DATA) && mem_data_ok) begin
        discard <= 1'b0;
      end else if (flush && (state != IDLE)) begin
        discard <= 1'b1;
      end

      if (flush) begin
        hold_valid <= 1'b0;
      end else if (data_accept) begin
        if (stall) begin
          hold_inst  <= mem_rdata;
          hold_pc    <= req_pc;
          hold_valid <= 1'b1;
        end else begin
          inst_o       <= mem_rdata;
          inst_pc_o    <= req_pc;
          inst_valid_o <= 1'b1;
        end
      end else if (hold_valid && !stall) begin
        inst_o       <= hold_inst;
        inst_pc_o    <= hold_pc;
        inst_valid_o <= 1'b1;
        hold_valid   <= 1'b0;
      end else if (misaligned) begin
        inst_o       <= NOP_INST;
        inst_pc_o    <= pc;
        inst_valid_o <= 1'b1;
        adel_o       <= 1'b1;
      end
    end
  end

endmodule
